// File: rtl/pulse_sched_pkg.sv
// Shared definitions for the pulse scheduler: phase codes, cfg_data field layout
// and the skip-zero phase search.
package pulse_sched_pkg;

  typedef enum logic [2:0] {
    PH_IDLE      = 3'd0,
    PH_PRE       = 3'd1,
    PH_RAMP_UP   = 3'd2,
    PH_PULSE     = 3'd3,
    PH_RAMP_DOWN = 3'd4,
    PH_POST      = 3'd5,
    PH_GAP       = 3'd6
  } phase_e;

  localparam int unsigned NUM_PHASES = 6;

  // cfg_data field indices, LSB upward
  localparam int unsigned F_PRE    = 0;
  localparam int unsigned F_RAMP   = 1;
  localparam int unsigned F_WIDTH  = 2;
  localparam int unsigned F_POST   = 3;
  localparam int unsigned F_GAP    = 4;
  localparam int unsigned F_FRAMES = 5;

  function automatic int unsigned cfg_lsb(input int unsigned field, input int unsigned pw);
    return field * pw;
  endfunction

  // First phase after `from` whose bit in `nz` (bit 0 = PRE) is set; PH_IDLE when the frame is exhausted.
  function automatic phase_e next_nonzero(input phase_e from, input logic [NUM_PHASES-1:0] nz);
    phase_e r;
    r = PH_IDLE;
    for (int i = int'(NUM_PHASES); i >= 1; i--) begin
      if (i > int'(from) && nz[3'(i - 1)]) r = phase_e'(3'(i));
    end
    return r;
  endfunction

endpackage

// File: rtl/pulse_phase_counter.sv
// Valid-sample counter for the current phase; flags the sample that completes a phase of length i_len.
module pulse_phase_counter #(
  parameter int unsigned PULSE_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   i_clear,
  input  logic                   i_valid,
  input  logic [PULSE_WIDTH-1:0] i_len,
  output logic                   o_term_c
);

  logic [PULSE_WIDTH-1:0] r_cnt;

  assign o_term_c = i_valid && (r_cnt == (i_len - PULSE_WIDTH'(1)));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_cnt <= '0;
    end else if (i_clear || o_term_c) begin
      r_cnt <= '0;
    end else if (i_valid) begin
      r_cnt <= r_cnt + PULSE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/axis_pulse_scheduler.sv
// Frame sequencer for the pulse-measurement datapath: steps PRE..GAP on valid ADC samples,
// drives excitation and integration gates, and counts completed frames.
module axis_pulse_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int unsigned PULSE_WIDTH = 16,
  parameter int unsigned CNTR_WIDTH  = 32
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [PULSE_WIDTH*5+CNTR_WIDTH-1:0] cfg_data,
  input  logic                              start,
  input  logic                              stop,
  input  logic                              s_axis_tvalid,
  output logic [2:0]                        phase,
  output logic                              drive,
  output logic                              offset_gate,
  output logic                              pulse_gate,
  output logic                              frame_done,
  output logic                              busy,
  output logic                              cfg_error,
  output logic [31:0]                       sts_data
);

  localparam int unsigned CFG_W      = PULSE_WIDTH * 5 + CNTR_WIDTH;
  localparam int unsigned LSB_PRE    = cfg_lsb(F_PRE, PULSE_WIDTH);
  localparam int unsigned LSB_RAMP   = cfg_lsb(F_RAMP, PULSE_WIDTH);
  localparam int unsigned LSB_WIDTH  = cfg_lsb(F_WIDTH, PULSE_WIDTH);
  localparam int unsigned LSB_POST   = cfg_lsb(F_POST, PULSE_WIDTH);
  localparam int unsigned LSB_GAP    = cfg_lsb(F_GAP, PULSE_WIDTH);
  localparam int unsigned LSB_FRAMES = cfg_lsb(F_FRAMES, PULSE_WIDTH);

  phase_e                  r_phase;
  logic [CFG_W-1:0]        r_cfg;
  logic                    r_stop_pend;
  logic [CNTR_WIDTH-1:0]   r_frame_cnt;
  logic                    r_cfg_err;
  logic                    r_drive;
  logic                    r_offset_gate;
  logic                    r_pulse_gate;
  logic                    r_frame_done;
  logic                    r_busy;

  phase_e                  w_phase_nxt;
  logic                    w_stop_nxt;
  logic [CNTR_WIDTH-1:0]   w_frame_nxt;
  logic                    w_cfg_load;
  logic                    w_err_nxt;
  logic                    w_frame_end;
  logic                    w_term;
  logic [PULSE_WIDTH-1:0]  w_cur_len;
  logic [CNTR_WIDTH-1:0]   w_frame_inc;
  logic                    w_limit;
  logic [NUM_PHASES-1:0]   w_sh_nz;
  logic [NUM_PHASES-1:0]   w_in_nz;

  wire [PULSE_WIDTH-1:0] w_sh_pre    = r_cfg[LSB_PRE +: PULSE_WIDTH];
  wire [PULSE_WIDTH-1:0] w_sh_ramp   = r_cfg[LSB_RAMP +: PULSE_WIDTH];
  wire [PULSE_WIDTH-1:0] w_sh_width  = r_cfg[LSB_WIDTH +: PULSE_WIDTH];
  wire [PULSE_WIDTH-1:0] w_sh_post   = r_cfg[LSB_POST +: PULSE_WIDTH];
  wire [PULSE_WIDTH-1:0] w_sh_gap    = r_cfg[LSB_GAP +: PULSE_WIDTH];
  wire [CNTR_WIDTH-1:0]  w_sh_frames = r_cfg[LSB_FRAMES +: CNTR_WIDTH];
  wire [PULSE_WIDTH-1:0] w_in_pre    = cfg_data[LSB_PRE +: PULSE_WIDTH];
  wire [PULSE_WIDTH-1:0] w_in_ramp   = cfg_data[LSB_RAMP +: PULSE_WIDTH];
  wire [PULSE_WIDTH-1:0] w_in_width  = cfg_data[LSB_WIDTH +: PULSE_WIDTH];
  wire [PULSE_WIDTH-1:0] w_in_post   = cfg_data[LSB_POST +: PULSE_WIDTH];
  wire [PULSE_WIDTH-1:0] w_in_gap    = cfg_data[LSB_GAP +: PULSE_WIDTH];

  assign w_sh_nz = {|w_sh_gap, |w_sh_post, |w_sh_ramp, |w_sh_width, |w_sh_ramp, |w_sh_pre};
  assign w_in_nz = {|w_in_gap, |w_in_post, |w_in_ramp, |w_in_width, |w_in_ramp, |w_in_pre};

  assign w_frame_inc = (&r_frame_cnt) ? r_frame_cnt : r_frame_cnt + CNTR_WIDTH'(1);
  assign w_limit     = (w_sh_frames != '0) && (w_frame_inc == w_sh_frames);

  always_comb begin
    w_cur_len = '0;
    case (r_phase)
      PH_PRE:                  w_cur_len = w_sh_pre;
      PH_RAMP_UP, PH_RAMP_DOWN: w_cur_len = w_sh_ramp;
      PH_PULSE:                w_cur_len = w_sh_width;
      PH_POST:                 w_cur_len = w_sh_post;
      PH_GAP:                  w_cur_len = w_sh_gap;
      default:                 w_cur_len = '0;
    endcase
  end

  pulse_phase_counter #(.PULSE_WIDTH(PULSE_WIDTH)) u_cnt (
    .aclk     (aclk),
    .areset   (areset),
    .i_clear  (r_phase == PH_IDLE),
    .i_valid  (s_axis_tvalid),
    .i_len    (w_cur_len),
    .o_term_c (w_term)
  );

  // Next-state: start acceptance, skip-zero advance, end-of-frame wrap or stop.
  always_comb begin
    w_phase_nxt = r_phase;
    w_stop_nxt  = r_stop_pend;
    w_frame_nxt = r_frame_cnt;
    w_cfg_load  = 1'b0;
    w_err_nxt   = r_cfg_err;
    w_frame_end = 1'b0;
    case (r_phase)
      PH_IDLE: begin
        w_stop_nxt = 1'b0;
        if (start) begin
          if (w_in_width == '0) begin
            w_err_nxt = 1'b1;
          end else begin
            w_err_nxt   = 1'b0;
            w_cfg_load  = 1'b1;
            w_frame_nxt = '0;
            w_stop_nxt  = stop;
            w_phase_nxt = next_nonzero(PH_IDLE, w_in_nz);
          end
        end
      end
      default: begin
        if (stop) w_stop_nxt = 1'b1;
        if (w_term) begin
          w_phase_nxt = next_nonzero(r_phase, w_sh_nz);
          if (w_phase_nxt == PH_IDLE) begin
            w_frame_end = 1'b1;
            w_frame_nxt = w_frame_inc;
            if (r_stop_pend || stop || w_limit) begin
              w_stop_nxt = 1'b0;
            end else if (w_in_width != '0) begin
              w_cfg_load  = 1'b1;
              w_phase_nxt = next_nonzero(PH_IDLE, w_in_nz);
            end else begin
              // A zero-width config at the wrap would never terminate; keep the current shadow.
              w_phase_nxt = next_nonzero(PH_IDLE, w_sh_nz);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_phase       <= PH_IDLE;
      r_cfg         <= '0;
      r_stop_pend   <= 1'b0;
      r_frame_cnt   <= '0;
      r_cfg_err     <= 1'b0;
      r_drive       <= 1'b0;
      r_offset_gate <= 1'b0;
      r_pulse_gate  <= 1'b0;
      r_frame_done  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_phase       <= w_phase_nxt;
      if (w_cfg_load) r_cfg <= cfg_data;
      r_stop_pend   <= w_stop_nxt;
      r_frame_cnt   <= w_frame_nxt;
      r_cfg_err     <= w_err_nxt;
      r_drive       <= (w_phase_nxt == PH_RAMP_UP) || (w_phase_nxt == PH_PULSE) ||
                       (w_phase_nxt == PH_RAMP_DOWN);
      r_offset_gate <= (w_phase_nxt == PH_PRE) || (w_phase_nxt == PH_POST);
      r_pulse_gate  <= (w_phase_nxt == PH_PULSE);
      r_frame_done  <= w_frame_end;
      r_busy        <= (w_phase_nxt != PH_IDLE);
    end
  end

  assign phase       = r_phase;
  assign drive       = r_drive;
  assign offset_gate = r_offset_gate;
  assign pulse_gate  = r_pulse_gate;
  assign frame_done  = r_frame_done;
  assign busy        = r_busy;
  assign cfg_error   = r_cfg_err;
  assign sts_data    = 32'(r_frame_cnt);

endmodule

// File: tb/tb_axis_pulse_scheduler.sv
// Self-checking bench for axis_pulse_scheduler: a sample-stream model expands each config into
// the expected per-sample phase sequence and a scoreboard compares every cycle.
`timescale 1ns/1ps
module tb_axis_pulse_scheduler;

  localparam int unsigned PW = 16;
  localparam int unsigned CW = 32;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic [PW*5+CW-1:0] cfg_data = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              s_axis_tvalid = 1'b0;
  logic [2:0]        phase;
  logic              drive, offset_gate, pulse_gate, frame_done, busy, cfg_error;
  logic [31:0]       sts_data;

  axis_pulse_scheduler #(.PULSE_WIDTH(PW), .CNTR_WIDTH(CW)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_data      (cfg_data),
    .start         (start),
    .stop          (stop),
    .s_axis_tvalid (s_axis_tvalid),
    .phase         (phase),
    .drive         (drive),
    .offset_gate   (offset_gate),
    .pulse_gate    (pulse_gate),
    .frame_done    (frame_done),
    .busy          (busy),
    .cfg_error     (cfg_error),
    .sts_data      (sts_data)
  );

  always #5 aclk = ~aclk;

  typedef struct {int pre; int ramp; int width; int post; int gap; int frames;} cfg_t;
  typedef struct {cfg_t c; bit toggle; int exp_frames;} vec_t;
  typedef struct {int ph; bit fd; bit err; int sts;} exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   last_sts = 0;

  function automatic logic [PW*5+CW-1:0] pack(input cfg_t c);
    return {32'(c.frames), 16'(c.gap), 16'(c.post), 16'(c.width), 16'(c.ramp), 16'(c.pre)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty t=%0t", tag, $time);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, ".phase"}, 32'(phase), 32'(e.ph));
    chk({tag, ".drive"}, 32'(drive), 32'(e.ph inside {2, 3, 4}));
    chk({tag, ".offset_gate"}, 32'(offset_gate), 32'(e.ph inside {1, 5}));
    chk({tag, ".pulse_gate"}, 32'(pulse_gate), 32'(e.ph == 3));
    chk({tag, ".busy"}, 32'(busy), 32'(e.ph != 0));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(e.fd));
    chk({tag, ".cfg_error"}, 32'(cfg_error), 32'(e.err));
    chk({tag, ".sts_data"}, sts_data, 32'(e.sts));
  endtask

  // Drives one run; the model counts valid samples consumed and looks up the expected phase.
  task automatic run_stream(input string tag, input cfg_t c, input int model_frames, input bit toggle,
                            input int stop_at, input int chg_at, input cfg_t chg, input bit stop_with_start);
    int   sq[$];
    bit   fe[$];
    int   len[6];
    int   n;
    int   nfd;
    bit   stop_fired;
    bit   chg_fired;
    exp_t e;
    len = '{c.pre, c.ramp, c.width, c.ramp, c.post, c.gap};
    for (int f = 0; f < model_frames; f++) begin
      for (int p = 0; p < 6; p++)
        for (int k = 0; k < len[p]; k++) begin
          sq.push_back(p + 1);
          fe.push_back(1'b0);
        end
      fe[fe.size() - 1] = 1'b1;
    end
    stop_fired = 1'b0;
    chg_fired  = 1'b0;
    n   = 0;
    nfd = 0;
    cfg_data = pack(c);
    start = 1'b1;
    stop = stop_with_start;
    s_axis_tvalid = 1'b0;
    e = '{sq[0], 1'b0, 1'b0, 0};
    exp_q.push_back(e);
    @(posedge aclk); #1;
    start = 1'b0;
    stop = 1'b0;
    compare_pop({tag, ".start"});
    for (int cyc = 0; cyc < 4 * sq.size() + 8 && n < sq.size(); cyc++) begin
      s_axis_tvalid = toggle ? (cyc % 2 == 0) : 1'b1;
      if (!stop_fired && stop_at >= 0 && n == stop_at) begin
        stop = 1'b1;
        stop_fired = 1'b1;
      end
      if (!chg_fired && chg_at >= 0 && n == chg_at) begin
        cfg_data = pack(chg);
        start = 1'b1;
        chg_fired = 1'b1;
      end
      e.fd = 1'b0;
      if (s_axis_tvalid) begin
        e.fd = fe[n];
        nfd += int'(fe[n]);
        n++;
      end
      e.ph  = (n < sq.size()) ? sq[n] : 0;
      e.err = 1'b0;
      e.sts = nfd;
      exp_q.push_back(e);
      @(posedge aclk); #1;
      start = 1'b0;
      stop = 1'b0;
      compare_pop(tag);
    end
    if (n != sq.size()) begin
      checks++;
      failures++;
      $display("FAIL %s run did not finish consumed=%0d required=%0d", tag, n, sq.size());
    end
    // Idle afterwards with samples still arriving: the run must not restart.
    s_axis_tvalid = 1'b1;
    repeat (2) begin
      e = '{0, 1'b0, 1'b0, nfd};
      exp_q.push_back(e);
      @(posedge aclk); #1;
      compare_pop({tag, ".idle"});
    end
    s_axis_tvalid = 1'b0;
    last_sts = nfd;
  endtask

  task automatic run_err(input string tag, input cfg_t c);
    exp_t e;
    cfg_data = pack(c);
    start = 1'b1;
    s_axis_tvalid = 1'b1;
    repeat (2) begin
      e = '{0, 1'b0, 1'b1, last_sts};
      exp_q.push_back(e);
      @(posedge aclk); #1;
      start = 1'b0;
      compare_pop(tag);
    end
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    cfg_t ca, cb, cc;
    bool_loop: begin end
    tbl[0] = '{'{2, 1, 4, 2, 3, 1}, 1'b0, 1};
    tbl[1] = '{'{2, 1, 4, 2, 3, 1}, 1'b1, 1};
    tbl[2] = '{'{2, 0, 4, 2, 0, 3}, 1'b0, 3};
    tbl[3] = '{'{2, 1, 0, 2, 3, 1}, 1'b0, 0};
    tbl[4] = '{'{1, 2, 5, 1, 1, 2}, 1'b1, 2};
    tbl[5] = '{'{0, 0, 1, 0, 0, 4}, 1'b0, 4};
    ca = '{1, 1, 3, 1, 1, 0};
    cb = '{3, 0, 2, 0, 2, 1};
    cc = '{1, 0, 2, 1, 0, 0};

    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    chk("reset.phase", 32'(phase), 0);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.drive", 32'(drive), 0);
    chk("reset.frame_done", 32'(frame_done), 0);
    chk("reset.cfg_error", 32'(cfg_error), 0);
    chk("reset.sts_data", sts_data, 0);
    areset = 1'b0;
    @(posedge aclk); #1;

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].c.width == 0)
        run_err($sformatf("vec%0d", i), tbl[i].c);
      else
        run_stream($sformatf("vec%0d", i), tbl[i].c, tbl[i].exp_frames, tbl[i].toggle,
                   -1, -1, tbl[i].c, 1'b0);
    end

    // Continuous run, stop mid-PULSE of frame 2; cfg change and busy start mid-frame are ignored
    run_stream("stop_mid", ca, 2, 1'b0, 11, 9, cb, 1'b0);
    chk("stop_mid.sts_final", sts_data, 2);
    run_stream("next_run", cb, 1, 1'b0, -1, -1, cb, 1'b0);

    // start and stop together in IDLE: exactly one frame of a continuous config
    run_stream("start_stop", cc, 1, 1'b0, -1, -1, cc, 1'b1);

    // stop alone in IDLE is ignored
    stop = 1'b1;
    s_axis_tvalid = 1'b1;
    @(posedge aclk); #1;
    stop = 1'b0;
    chk("idle_stop.phase", 32'(phase), 0);
    chk("idle_stop.busy", 32'(busy), 0);
    cc.frames = 2;
    run_stream("after_idle_stop", cc, 2, 1'b1, -1, -1, cc, 1'b0);

    // Asynchronous reset during PULSE
    begin
      bit seen;
      seen = 1'b0;
      cfg_data = pack(tbl[0].c);
      start = 1'b1;
      s_axis_tvalid = 1'b1;
      @(posedge aclk); #1;
      start = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        if (phase == 3'd3) seen = 1'b1;
        else begin
          @(posedge aclk); #1;
        end
      end
      chk("rst.reached_pulse", 32'(seen), 1);
      #2 areset = 1'b1;
      #1;
      chk("rst.phase", 32'(phase), 0);
      chk("rst.drive", 32'(drive), 0);
      chk("rst.pulse_gate", 32'(pulse_gate), 0);
      chk("rst.offset_gate", 32'(offset_gate), 0);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.sts_data", sts_data, 0);
      @(posedge aclk); #1;
      areset = 1'b0;
      repeat (3) begin
        @(posedge aclk); #1;
        chk("rst.idle_phase", 32'(phase), 0);
        chk("rst.idle_busy", 32'(busy), 0);
      end
      s_axis_tvalid = 1'b0;
      last_sts = 0;
      run_stream("post_reset", tbl[0].c, 1, 1'b0, -1, -1, tbl[0].c, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
